// File: rtl/fetch_aligner_pkg.sv
// Shared fetch-path types: fetch FSM states, halfword buffer count, PC steps.
package common;
  typedef logic [31:0] instruction_type;
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_type;
  typedef logic [1:0] hw_count_type;
  localparam logic [31:0] PC_STEP_C = 32'd2;
  localparam logic [31:0] PC_STEP_I = 32'd4;
endpackage

// File: rtl/fetch_aligner_decompressor.sv
// RV32C to RV32I expansion; unsupported or illegal encodings expand to 32'h0.
module decompressor import common::*; (
  input  logic [15:0]     hw,
  output instruction_type instr
);
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm6;

  assign rd   = hw[11:7];
  assign rs2  = hw[6:2];
  assign rdp  = {2'b01, hw[4:2]};
  assign rs1p = {2'b01, hw[9:7]};
  assign imm6 = {{6{hw[12]}}, hw[12], hw[6:2]};

  always_comb begin
    instr = 32'h0;
    case ({hw[15:13], hw[1:0]})
      5'b000_00: if (hw[12:5] != 8'h0)
                   instr = {2'b00, hw[10:7], hw[12:11], hw[5], hw[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
      5'b010_00: instr = {5'b0, hw[5], hw[12:10], hw[6], 2'b00, rs1p, 3'b010, rdp, 7'h03};
      5'b110_00: instr = {5'b0, hw[5], hw[12], rdp, rs1p, 3'b010, hw[11:10], hw[6], 2'b00, 7'h23};
      5'b000_01: instr = {imm6, rd, 3'b000, rd, 7'h13};
      5'b001_01, 5'b101_01:
        instr = {hw[12], hw[8], hw[10:9], hw[6], hw[7], hw[2], hw[11], hw[5:3], hw[12],
                 {8{hw[12]}}, 4'b0, ~hw[15], 7'h6f};
      5'b010_01: instr = {imm6, 5'd0, 3'b000, rd, 7'h13};
      5'b011_01: if (rd == 5'd2)
                   instr = {{3{hw[12]}}, hw[4:3], hw[5], hw[2], hw[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13};
                 else
                   instr = {{15{hw[12]}}, hw[6:2], rd, 7'h37};
      5'b100_01:
        case (hw[11:10])
          2'b00: instr = {7'b0, hw[6:2], rs1p, 3'b101, rs1p, 7'h13};
          2'b01: instr = {7'b0100000, hw[6:2], rs1p, 3'b101, rs1p, 7'h13};
          2'b10: instr = {imm6, rs1p, 3'b111, rs1p, 7'h13};
          default:
            case (hw[6:5])
              2'b00:   instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
              2'b01:   instr = {7'b0, rdp, rs1p, 3'b100, rs1p, 7'h33};
              2'b10:   instr = {7'b0, rdp, rs1p, 3'b110, rs1p, 7'h33};
              default: instr = {7'b0, rdp, rs1p, 3'b111, rs1p, 7'h33};
            endcase
        endcase
      5'b110_01, 5'b111_01:
        instr = {{4{hw[12]}}, hw[6:5], hw[2], 5'd0, rs1p, 2'b00, hw[13], hw[11:10], hw[4:3], hw[12], 7'h63};
      5'b000_10: instr = {7'b0, hw[6:2], rd, 3'b001, rd, 7'h13};
      5'b010_10: instr = {4'b0, hw[3:2], hw[12], hw[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
      5'b100_10:
        if (!hw[12])
          instr = (rs2 == 5'd0) ? {12'b0, rd, 3'b000, 5'd0, 7'h67} : {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
        else if (rd == 5'd0 && rs2 == 5'd0)
          instr = 32'h0010_0073;
        else
          instr = (rs2 == 5'd0) ? {12'b0, rd, 3'b000, 5'd1, 7'h67} : {7'b0, rs2, rd, 3'b000, rd, 7'h33};
      5'b110_10: instr = {4'b0, hw[8:7], hw[12], rs2, 5'd2, 3'b010, hw[11:9], 2'b00, 7'h23};
      default:   instr = 32'h0;
    endcase
  end
endmodule

// File: rtl/fetch_aligner.sv
// Word fetcher feeding a 3-halfword buffer; emits aligned 16/32-bit instructions.
module fetch_aligner import common::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  input  logic            flush,
  input  logic [31:0]     flush_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output instruction_type out_instr,
  output logic [31:0]     out_pc,
  output logic            out_compressed
);
  fetch_state_type  state, state_nxt;
  logic [2:0][15:0] hw_buf, buf_sh, buf_nxt;
  hw_count_type     count, consume, cnt_sh, cnt_nxt;
  logic [31:0]      pc_q, fetch_addr;
  logic             skip_low, is_c, fire, take;
  instruction_type  dec_instr;

  decompressor u_dec (.hw(hw_buf[0]), .instr(dec_instr));

  assign is_c           = hw_buf[0][1:0] != 2'b11;
  assign out_valid      = (is_c ? (count != 2'd0) : (count >= 2'd2)) && !flush && !reset;
  assign out_instr      = is_c ? dec_instr : {hw_buf[1], hw_buf[0]};
  assign out_compressed = is_c;
  assign out_pc         = pc_q;
  assign fire           = out_valid && out_ready;
  assign imem_req       = (state == IDLE) && (count <= 2'd1) && !flush && !reset;
  assign imem_addr      = fetch_addr;
  assign take           = (state == WAIT) && imem_valid;

  // Flush-or-not, a response ends both WAIT and DISCARD: nothing else is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (imem_req) state_nxt = WAIT;
      WAIT:    if (imem_valid) state_nxt = IDLE;
               else if (flush) state_nxt = DISCARD;
      DISCARD: if (imem_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Consume from the head first, then append the response behind what remains.
  always_comb begin
    consume = 2'd0;
    if (fire) consume = is_c ? 2'd1 : 2'd2;
    buf_sh = hw_buf;
    if (consume == 2'd1)      buf_sh = {16'h0, hw_buf[2], hw_buf[1]};
    else if (consume == 2'd2) buf_sh = {32'h0, hw_buf[2]};
    cnt_sh  = count - consume;
    buf_nxt = buf_sh;
    cnt_nxt = cnt_sh;
    if (take) begin
      for (int i = 0; i < 3; i++) begin
        if (skip_low) begin
          if (i == int'(cnt_sh)) buf_nxt[i] = imem_data[31:16];
        end else begin
          if (i == int'(cnt_sh))     buf_nxt[i] = imem_data[15:0];
          if (i == int'(cnt_sh) + 1) buf_nxt[i] = imem_data[31:16];
        end
      end
      cnt_nxt = cnt_sh + (skip_low ? 2'd1 : 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hw_buf     <= '0;
      count      <= 2'd0;
      pc_q       <= RESET_PC;
      fetch_addr <= {RESET_PC[31:2], 2'b00};
      skip_low   <= RESET_PC[1];
    end else begin
      state <= state_nxt;
      if (flush) begin
        count      <= 2'd0;
        pc_q       <= flush_pc;
        fetch_addr <= {flush_pc[31:2], 2'b00};
        skip_low   <= flush_pc[1];
      end else begin
        hw_buf <= buf_nxt;
        count  <= cnt_nxt;
        if (take) begin
          skip_low   <= 1'b0;
          fetch_addr <= fetch_addr + PC_STEP_I;
        end
        if (fire) pc_q <= pc_q + (is_c ? PC_STEP_C : PC_STEP_I);
      end
    end
  end
endmodule

// File: tb/tb_fetch_aligner.sv
// Random program image, random memory latency, flushes and resets; scoreboard of expected instructions.
module tb_fetch_aligner;
  import common::*;

  logic            clk = 1'b0;
  logic            reset, imem_req, imem_valid, flush, out_valid, out_ready, out_compressed;
  logic [31:0]     imem_addr, imem_data, flush_pc, out_pc;
  instruction_type out_instr;

  fetch_aligner #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .flush(flush), .flush_pc(flush_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_compressed(out_compressed)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; logic comp; } exp_t;

  localparam int NC = 8;
  logic [15:0] c_enc [NC] = '{16'h4501, 16'h0001, 16'h0505, 16'h852e,
                              16'h952e, 16'h8082, 16'h157d, 16'h4108};
  logic [31:0] c_exp [NC] = '{32'h0000_0513, 32'h0000_0013, 32'h0015_0513, 32'h00b0_0533,
                              32'h00b5_0533, 32'h0000_8067, 32'hfff5_0513, 32'h0005_2503};

  exp_t        exp_q[$];
  logic [15:0] mem [logic [31:0]];
  logic [31:0] starts[$];
  logic [31:0] exp_fetch = 32'h0, pend_addr = 32'h0;
  logic        pend = 1'b0;
  int          delay = 0, n_vec = 0, n_err = 0, n_fire = 0;

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 16'h0001;
  endfunction

  function automatic logic [31:0] expand(input logic [15:0] h);
    for (int i = 0; i < NC; i++) if (c_enc[i] == h) return c_exp[i];
    return 32'hdead_beef;
  endfunction

  // Walk the image as an instruction stream starting at pc.
  task automatic load_stream(input logic [31:0] start);
    logic [31:0] pc;
    logic [15:0] h;
    exp_t e;
    exp_q.delete();
    pc = start;
    for (int k = 0; k < 48; k++) begin
      h = hw_at(pc);
      e.pc = pc;
      if (h[1:0] != 2'b11) begin
        e.instr = expand(h); e.comp = 1'b1; pc = pc + 32'd2;
      end else begin
        e.instr = {hw_at(pc + 32'd2), h}; e.comp = 1'b0; pc = pc + 32'd4;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic place(inout logic [31:0] pc, input bit force_c);
    logic [31:0] r;
    starts.push_back(pc);
    r = $urandom;
    if (force_c || r[0]) begin
      mem[pc] = c_enc[$urandom_range(0, NC-1)]; pc = pc + 32'd2;
    end else begin
      r = $urandom;
      mem[pc] = {r[15:2], 2'b11}; mem[pc + 32'd2] = r[31:16]; pc = pc + 32'd4;
    end
  endtask

  // Monitor: request rules, handshakes against the scoreboard, stall stability.
  initial begin
    exp_t        e;
    logic [31:0] p_pc, p_instr;
    logic        p_comp, have_prev, prev_rst;
    have_prev = 1'b0; prev_rst = 1'b1; p_pc = '0; p_instr = '0; p_comp = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        prev_rst = 1'b1; have_prev = 1'b0;
        continue;
      end
      if (prev_rst) chk("first_req_after_reset", {31'b0, imem_req}, 32'd1);
      prev_rst = 1'b0;
      if (imem_req) begin
        chk("one_outstanding", {31'b0, pend}, 32'd0);
        chk("imem_addr", imem_addr, exp_fetch);
        if (exp_q.size() > 0)
          chk("fetch_ahead", ($signed(exp_fetch - exp_q[0].pc) <= 2) ? 32'd1 : 32'd0, 32'd1);
        pend = 1'b1; pend_addr = imem_addr; delay = $urandom_range(0, 3);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (flush) begin
        chk("flush_blocks_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        if (have_prev) begin
          chk("stall_valid", {31'b0, out_valid}, 32'd1);
          chk("stall_pc", out_pc, p_pc);
          chk("stall_instr", out_instr, p_instr);
          chk("stall_comp", {31'b0, out_compressed}, {31'b0, p_comp});
        end
        if (out_valid && out_ready) begin
          n_fire++;
          if (exp_q.size() == 0) chk("unexpected_output", out_pc, 32'hffff_ffff);
          else begin
            e = exp_q.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_instr", out_instr, e.instr);
            chk("out_compressed", {31'b0, out_compressed}, {31'b0, e.comp});
          end
        end
      end
      have_prev = out_valid && !out_ready && !flush;
      p_pc = out_pc; p_instr = out_instr; p_comp = out_compressed;
    end
  end

  // Driver: memory responder, consumer back-pressure, flushes and resets.
  initial begin
    logic [31:0] pc;
    int rst_cnt, stall;
    reset = 1'b1; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
    imem_valid = 1'b0; imem_data = '0;
    rst_cnt = 3; stall = 0;
    // Fixed head: two c.li in one word, then a c.li and a 32-bit op straddling words.
    mem[32'h0] = 16'h4501; mem[32'h2] = 16'h4501; mem[32'h4] = 16'h4501;
    mem[32'h6] = 16'h0013; mem[32'h8] = 16'h0000; mem[32'ha] = 16'h0093; mem[32'hc] = 16'h0000;
    starts = '{32'h0, 32'h2, 32'h4, 32'h6, 32'ha};
    pc = 32'he;
    while (pc < 32'h400) place(pc, 1'b0);
    pc = 32'hffff_fff0;
    while (pc != 32'h0) place(pc, pc == 32'hffff_fffe);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk); #1;
      flush = 1'b0; imem_valid = 1'b0; imem_data = $urandom;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) begin
          reset = 1'b0; load_stream(32'h0); exp_fetch = 32'h0;
        end
        continue;
      end
      if ($urandom_range(0, 799) == 0) begin
        reset = 1'b1; rst_cnt = 2; pend = 1'b0;
        continue;
      end
      if (pend) begin
        if (delay == 0) begin
          imem_valid = 1'b1;
          imem_data = {hw_at(pend_addr + 32'd2), hw_at(pend_addr)};
          pend = 1'b0;
        end else delay--;
      end
      if ($urandom_range(0, 39) == 0) begin
        flush = 1'b1;
        flush_pc = starts[$urandom_range(0, starts.size() - 1)];
        load_stream(flush_pc);
        exp_fetch = {flush_pc[31:2], 2'b00};
      end
      if (stall > 0) stall--;
      else if ($urandom_range(0, 99) == 0) stall = 5;
      out_ready = (stall == 0) && (exp_q.size() >= 4) && ($urandom_range(0, 3) != 0);
    end
    chk("progress", (n_fire > 300) ? 32'd1 : 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_aligner.md
FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the halfword-aligned PC loaded on reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request; one word per request.
REQ-005 imem_addr  output  32  word-aligned fetch address, bits [1:0] = 0.
REQ-006 imem_valid  input  1  response strobe for the single outstanding request.
REQ-007 imem_data  input  32  fetched word, little-endian halfwords.
REQ-008 flush  input  1  redirect request from branch/jump logic.
REQ-009 flush_pc  input  32  redirect target, bit 0 = 0.
REQ-010 out_valid  output  1  out_instr/out_pc hold a complete instruction.
REQ-011 out_ready  input  1  consumer accepts the instruction when out_valid is also high.
REQ-012 out_instr  output  32 (instruction_type)  expanded 32-bit instruction.
REQ-013 out_pc  output  32  address of out_instr.
REQ-014 out_compressed  output  1  out_instr came from a 16-bit encoding; PC step 2, otherwise 4.

Function
REQ-015 The block SHALL hold a 3-halfword buffer with count 0..3; halfword 0 is the oldest and sits at out_pc.
REQ-016 A compressed instruction is available when count>=1 and hw0[1:0]!=2'b11; out_instr = decompressor(hw0); out_compressed=1.
REQ-017 An uncompressed instruction is available when count>=2 and hw0[1:0]==2'b11; out_instr = {hw1,hw0}; out_compressed=0.
REQ-018 out_valid SHALL be high exactly when REQ-016 or REQ-017 holds and flush is low; decode is combinational from the buffer, latency 0.
REQ-019 On out_valid&&out_ready, the buffer SHALL shift by 1 (compressed) or 2 halfwords, and out_pc SHALL advance by 2 or 4 (mod 2^32 wrap).
REQ-020 While out_valid&&!out_ready, out_instr, out_pc and out_compressed SHALL stay stable.
REQ-021 Fetch FSM states: IDLE, WAIT, DISCARD.
REQ-022 IDLE: when count<=1 and flush low, assert imem_req for one cycle with imem_addr=fetch_addr, then go to WAIT.
REQ-023 WAIT: on imem_valid, append halfwords (both, or only [31:16] if skip_low is set), clear skip_low, set fetch_addr+=4, then go to IDLE; the count update includes any same-cycle consumption.
REQ-024 At most one request SHALL be outstanding, so the count never exceeds 3.
REQ-025 Flush in any state SHALL make count=0, out_pc=flush_pc, fetch_addr={flush_pc[31:2],2'b00}, and skip_low=flush_pc[1].
REQ-026 Flush in WAIT without same-cycle imem_valid SHALL go to DISCARD; DISCARD drops the next imem_valid data, then goes to IDLE.
REQ-027 Flush SHALL take priority over a same-cycle imem_valid (data dropped, state IDLE) and over same-cycle out_valid&&out_ready (no handshake occurs).
REQ-028 Flush in DISCARD SHALL update the targets and stay in DISCARD.
REQ-029 A 32-bit instruction straddling a word boundary SHALL be emitted only once both halves are buffered.

Reset
REQ-030 While reset is high, the block SHALL set state=IDLE, count=0, out_pc=RESET_PC, fetch_addr={RESET_PC[31:2],2'b00}, skip_low=RESET_PC[1], imem_req=0, out_valid=0.
REQ-031 Reset mid-request SHALL abandon the outstanding response; the imem side is also reset, and no DISCARD is needed.
REQ-032 The first imem_req SHALL occur in the first cycle after reset deasserts.

Structure
REQ-033 The package common SHALL hold the fetch_state_type enum, the halfword-count type, and the PC step constants 2 and 4; instruction_type is reused.
REQ-034 The block SHALL instantiate exactly one decompressor sub-module, fed with hw0.

Verification
REQ-035 Reset RESET_PC=0, memory words 0x00000013, 0x00000093 -> out_pc 0 then 4, out_compressed=0, one request per word.
REQ-036 Word 0x45014501 (two c.li a0,0) -> two compressed outputs at pc 0 and 2, both expanding to ADDI x10,x0,0; second fetch is issued when count<=1.
REQ-037 Word0 = {hw 0x0013 upper, 0x4501 lower}, word1 = 0x00000000 -> pc 0 compressed, then pc 2 uncompressed 0x00000013, emitted only after word1 arrives.
REQ-038 flush_pc=0x102 while in WAIT -> next response discarded, fetch at 0x100, low halfword skipped, first out_pc=0x102.
REQ-039 out_ready held low for 5 cycles with out_valid high -> outputs constant, no extra fetches beyond count<=1 rule, and count never exceeds 3.
REQ-040 flush and imem_valid in the same cycle, and flush with out_ready high -> data dropped, no handshake counted, out_pc=flush_pc.
